// File: rtl/reg_file_2r1w_pkg.sv
// Shared sizing and helpers for the 2-read/1-write register file.
package reg_file_2r1w_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [NREGS-1:0]  line_t;

  function automatic line_t onehot(input addr_t idx);
    line_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Pipeline-facing bus of the register file: one write port, two registered read ports.
// RdEn is the advance strobe (no back-pressure); SrcValid marks that the operand stage holds a live capture.
interface reg_file_2r1w_if;
  import reg_file_2r1w_pkg::*;

  logic  WriteReg;
  addr_t DstReg;
  data_t DstData;
  addr_t SrcReg1;
  addr_t SrcReg2;
  logic  RdEn;
  logic  Flush;
  data_t SrcData1;
  data_t SrcData2;
  logic  SrcValid;
  line_t RdLine1;
  line_t RdLine2;

  modport master (
    output WriteReg, DstReg, DstData, SrcReg1, SrcReg2, RdEn, Flush,
    input  SrcData1, SrcData2, SrcValid, RdLine1, RdLine2
  );

  modport slave (
    input  WriteReg, DstReg, DstData, SrcReg1, SrcReg2, RdEn, Flush,
    output SrcData1, SrcData2, SrcValid, RdLine1, RdLine2
  );

endinterface

// File: rtl/reg_file_2r1w_read_mux.sv
// Combinational 8:1 read select with same-cycle write bypass, one per read port.
module reg_read_mux_8_1
  import reg_file_2r1w_pkg::*;
(
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  addr_t                        sel,
  input  logic                         byp_en,
  input  addr_t                        byp_idx,
  input  data_t                        byp_data,
  output data_t                        data
);

  always_comb begin
    data = regs[sel];
    if (byp_en && (byp_idx == sel)) begin
      data = byp_data;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// 8x16 register file: array, write decode and the ID/EX operand registers.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  reg_file_2r1w_if.slave  bus
);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  line_t                        we_line;
  data_t                        rd_data1;
  data_t                        rd_data2;

  always_comb begin
    we_line = '0;
    if (bus.WriteReg) begin
      we_line = onehot(bus.DstReg);
    end
  end

  // Writes commit regardless of stall or flush; only reset blocks them.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_line[i]) begin
          regs[i] <= bus.DstData;
        end
      end
    end
  end

  reg_read_mux_8_1 u_mux1 (
    .regs     (regs),
    .sel      (bus.SrcReg1),
    .byp_en   (bus.WriteReg),
    .byp_idx  (bus.DstReg),
    .byp_data (bus.DstData),
    .data     (rd_data1)
  );

  reg_read_mux_8_1 u_mux2 (
    .regs     (regs),
    .sel      (bus.SrcReg2),
    .byp_en   (bus.WriteReg),
    .byp_idx  (bus.DstReg),
    .byp_data (bus.DstData),
    .data     (rd_data2)
  );

  // Held operands are deliberately not refreshed by later writes.
  always_ff @(posedge clk) begin
    if (rst || bus.Flush) begin
      bus.SrcData1 <= '0;
      bus.SrcData2 <= '0;
      bus.SrcValid <= 1'b0;
      bus.RdLine1  <= '0;
      bus.RdLine2  <= '0;
    end else if (bus.RdEn) begin
      bus.SrcData1 <= rd_data1;
      bus.SrcData2 <= rd_data2;
      bus.SrcValid <= 1'b1;
      bus.RdLine1  <= onehot(bus.SrcReg1);
      bus.RdLine2  <= onehot(bus.SrcReg2);
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w with hand-computed expected operands.
module tb_reg_file_2r1w;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  reg_file_2r1w_if bus ();

  reg_file_2r1w dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.WriteReg = 1'b0;
    bus.DstReg   = '0;
    bus.DstData  = '0;
    bus.SrcReg1  = '0;
    bus.SrcReg2  = '0;
    bus.RdEn     = 1'b0;
    bus.Flush    = 1'b0;
  endtask

  task automatic drive_write(input logic [2:0] idx, input logic [15:0] val);
    bus.WriteReg = 1'b1;
    bus.DstReg   = idx;
    bus.DstData  = val;
  endtask

  task automatic drive_read(input logic [2:0] a1, input logic [2:0] a2);
    bus.RdEn    = 1'b1;
    bus.SrcReg1 = a1;
    bus.SrcReg2 = a2;
  endtask

  task automatic check_ops(input string tag, input logic [15:0] d1, input logic [15:0] d2,
                           input logic v, input logic [7:0] l1, input logic [7:0] l2);
    check({tag, ".d1"},    {16'h0, bus.SrcData1}, {16'h0, d1});
    check({tag, ".d2"},    {16'h0, bus.SrcData2}, {16'h0, d2});
    check({tag, ".valid"}, {31'h0, bus.SrcValid}, {31'h0, v});
    check({tag, ".line1"}, {24'h0, bus.RdLine1},  {24'h0, l1});
    check({tag, ".line2"}, {24'h0, bus.RdLine2},  {24'h0, l2});
  endtask

  initial begin
    logic [15:0] exp_regs [8];
    logic [7:0]  oh;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive_idle();
    step();
    step();
    rst = 1'b0;
    check_ops("reset", 16'h0000, 16'h0000, 1'b0, 8'h00, 8'h00);

    // first read after reset
    drive_read(3'd3, 3'd7);
    step();
    check_ops("rd37", 16'h0000, 16'h0000, 1'b1, 8'h08, 8'h80);

    // plain write then read; R0 is an ordinary register
    drive_idle();
    drive_write(3'd5, 16'hBEEF);
    step();
    drive_write(3'd0, 16'h0F0F);
    step();
    drive_idle();
    drive_read(3'd5, 3'd0);
    step();
    check_ops("rd5_0", 16'hBEEF, 16'h0F0F, 1'b1, 8'h20, 8'h01);

    exp_regs = '{16'h0F0F, 16'h0, 16'h0, 16'h0, 16'h0, 16'hBEEF, 16'h0, 16'h0};
    for (int i = 0; i < 8; i++) begin
      drive_read(i[2:0], 3'(7 - i));
      step();
      oh = 8'h01 << i;
      check($sformatf("sweep.p1.r%0d", i), {16'h0, bus.SrcData1}, {16'h0, exp_regs[i]});
      check($sformatf("sweep.p2.r%0d", 7 - i), {16'h0, bus.SrcData2}, {16'h0, exp_regs[7 - i]});
      check($sformatf("sweep.line1.%0d", i), {24'h0, bus.RdLine1}, {24'h0, oh});
    end

    // same-cycle bypass, both ports on one write
    drive_write(3'd2, 16'h1234);
    drive_read(3'd2, 3'd2);
    step();
    check_ops("byp_both", 16'h1234, 16'h1234, 1'b1, 8'h04, 8'h04);

    // bypass on port 1 only; port 2 reads the array
    drive_write(3'd3, 16'h3333);
    drive_read(3'd3, 3'd2);
    step();
    check_ops("byp_p1", 16'h3333, 16'h1234, 1'b1, 8'h08, 8'h04);

    // stall holds operands even while the source register changes
    drive_idle();
    drive_write(3'd1, 16'hAAAA);
    step();
    drive_idle();
    drive_read(3'd1, 3'd5);
    step();
    check_ops("ld_r1", 16'hAAAA, 16'hBEEF, 1'b1, 8'h02, 8'h20);
    bus.RdEn    = 1'b0;
    bus.SrcReg1 = 3'd2;
    drive_write(3'd1, 16'h5555);
    for (int c = 0; c < 3; c++) begin
      step();
      check_ops($sformatf("hold%0d", c), 16'hAAAA, 16'hBEEF, 1'b1, 8'h02, 8'h20);
    end
    drive_idle();
    drive_read(3'd1, 3'd5);
    step();
    check_ops("after_hold", 16'h5555, 16'hBEEF, 1'b1, 8'h02, 8'h20);

    // flush beats RdEn, write still commits
    bus.Flush = 1'b1;
    drive_write(3'd4, 16'h00FF);
    drive_read(3'd4, 3'd1);
    step();
    check_ops("flush", 16'h0000, 16'h0000, 1'b0, 8'h00, 8'h00);
    drive_idle();
    drive_read(3'd4, 3'd3);
    step();
    check_ops("rd_r4", 16'h00FF, 16'h3333, 1'b1, 8'h10, 8'h08);

    // reset drops the write presented in the same cycle
    drive_idle();
    drive_write(3'd6, 16'hCAFE);
    step();
    drive_idle();
    drive_read(3'd6, 3'd6);
    step();
    check_ops("rd_r6", 16'hCAFE, 16'hCAFE, 1'b1, 8'h40, 8'h40);
    rst = 1'b1;
    drive_write(3'd6, 16'h7777);
    drive_read(3'd6, 3'd5);
    step();
    rst = 1'b0;
    check_ops("rst_mid", 16'h0000, 16'h0000, 1'b0, 8'h00, 8'h00);
    drive_idle();
    drive_read(3'd6, 3'd5);
    step();
    check_ops("post_rst", 16'h0000, 16'h0000, 1'b1, 8'h40, 8'h20);

    // final report
    drive_idle();
    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 8-entry x 16-bit register file with one write port and two read ports.
- Sits on the read side of the write-wordline decode.
- Both read ports are registered: operands appear one cycle after the addresses are presented, at the ID/EX boundary.
- Same-cycle write-to-read bypass, stall (hold) and flush are handled inside the block so the pipeline sees a single clean operand stage.

Parameters:
- DATA_W, 16, width of each register and data port
- ADDR_W, 3, register index width; entry count NREGS = 2**ADDR_W (8)

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  reset, synchronous and active-high
- WriteReg  input  1  write enable for this cycle
- DstReg  input  ADDR_W  write register index
- DstData  input  DATA_W  write data
- SrcReg1  input  ADDR_W  read port 1 index
- SrcReg2  input  ADDR_W  read port 2 index
- RdEn  input  1  advance: capture new operands this cycle; low = hold (stall)
- Flush  input  1  squash the operand stage
- SrcData1  output  DATA_W  registered read data, port 1
- SrcData2  output  DATA_W  registered read data, port 2
- SrcValid  output  1  operand stage holds a valid capture
- RdLine1  output  NREGS  one-hot of the registered port-1 index (debug/scoreboard)
- RdLine2  output  NREGS  one-hot of the registered port-2 index

Behaviour:
- Reset (rst high at posedge): all 8 registers <= 0; SrcData1/2 <= 0; SrcValid <= 0; RdLine1/2 <= 8'h00.
  - Reset wins over every other input that cycle.
  - A write presented in the reset cycle is dropped.
- Write: at posedge with WriteReg=1, regs[DstReg] <= DstData. Exactly one entry changes.
  - Internal write select is a one-hot decode of DstReg, gated by WriteReg.
  - WriteReg=0 leaves the array unchanged.
  - Writes to register 0 are ordinary writes; there is no hardwired zero.
- Read, latency 1: at posedge with RdEn=1 and Flush=0:
  - SrcDataN <= (WriteReg && DstReg==SrcRegN) ? DstData : regs[SrcRegN].
  - SrcValid <= 1.
  - RdLineN <= one-hot(SrcRegN).
- Bypass: applies per port independently. Both ports may bypass the same write in the same cycle.
- Stall (RdEn=0, Flush=0): SrcData1/2, SrcValid and RdLine1/2 hold their values.
  - Writes still commit.
  - Held operands are NOT refreshed by a later write to the same index. Forwarding beyond this stage is the hazard unit's job.
- Flush=1: SrcData1/2 <= 0; SrcValid <= 0; RdLine1/2 <= 0.
  - Flush has priority over RdEn.
  - Writes still commit during a flush.
- Priority at posedge: rst > Flush > RdEn > hold.
- Outputs are purely registered; no combinational path from any input to any output.
- Read muxing is a full 8:1 select on the index. No X is allowed on any output after reset for any index value.

Decomposition:
- Shared package:
  - DATA_W = 16, ADDR_W = 3, NREGS = 8.
  - Function onehot(idx), returning an NREGS-bit one-hot vector.
- Sub-module: reg_read_mux_8_1.
  - Combinational 8:1 DATA_W selector with bypass compare.
  - Instantiated twice, once per read port.
- Storage, write decode and output registers stay in the top module.

Test Plan:
- Reset, then RdEn=1, SrcReg1=3, SrcReg2=7 -> next cycle SrcData1=0, SrcData2=0, SrcValid=1, RdLine1=8'h08, RdLine2=8'h80.
- Write R5=16'hBEEF (WriteReg=1), next cycle RdEn=1, SrcReg1=5 -> SrcData1=16'hBEEF one cycle later; all other registers still read 0.
- Same cycle: WriteReg=1, DstReg=2, DstData=16'h1234, SrcReg1=SrcReg2=2, RdEn=1 -> both SrcData=16'h1234 next cycle (bypass).
- Load R1=16'hAAAA on port 1, then hold RdEn=0 for 3 cycles while writing R1=16'h5555 -> SrcData1 stays 16'hAAAA. RdEn=1 afterwards -> 16'h5555.
- Flush=1 with RdEn=1 and WriteReg=1, DstReg=4, DstData=16'h00FF -> SrcValid=0 and SrcData1/2=0 next cycle; a later read of R4 returns 16'h00FF.
- R6=16'hCAFE written; rst=1 together with WriteReg=1, DstReg=6, DstData=16'h7777 -> read of R6 after reset returns 0, all outputs 0, SrcValid=0.
